// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - PSRAM read/write command master framing requests as UART bytes
// Sends a 4/6-byte command frame, then for reads collects a two-byte response or times out.
module uart_cmd_master #(
   parameter int TIMEOUT_US = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1us,
   input  logic        i_stb,
   input  logic        i_we,
   input  logic [23:0] i_addr,
   input  logic [15:0] i_din,
   output logic        o_busy,
   output logic [15:0] o_dout,
   output logic        o_done,
   output logic        o_timeout,
   output logic        uart_tx_write,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_busy,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data
);
   localparam int CW = (TIMEOUT_US < 1) ? 1 : $clog2(TIMEOUT_US + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_US);

   typedef enum logic [2:0] {IDLE, SEND, GAP, RESP_HI, RESP_LO, DONE} state_t;

   state_t        state_q, state_d;
   logic          we_q;
   logic [23:0]   addr_q;
   logic [15:0]   din_q;
   logic [2:0]    idx_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    hi_q;
   logic [15:0]   dout_q;
   logic          tx_write_q;
   logic [7:0]    tx_data_q;
   logic          to_q;

   logic [7:0]    frame_byte;
   logic [2:0]    frame_len;
   logic          tx_fire;
   logic          resp_st;
   logic          cnt_hit;

   always_comb begin
      frame_byte = 8'h00;
      case (idx_q)
         3'd0:    frame_byte = {7'd0, we_q};
         3'd1:    frame_byte = addr_q[7:0];
         3'd2:    frame_byte = addr_q[15:8];
         3'd3:    frame_byte = addr_q[23:16];
         3'd4:    frame_byte = din_q[7:0];
         3'd5:    frame_byte = din_q[15:8];
         default: frame_byte = 8'h00;
      endcase
   end

   assign frame_len = we_q ? 3'd6 : 3'd4;
   assign tx_fire   = (state_q == SEND) && !uart_tx_busy;
   assign resp_st   = (state_q == RESP_HI) || (state_q == RESP_LO);

   // Counter idles at zero outside the response window, so it is clear on RESP_HI entry.
   always_comb begin
      cnt_d = '0;
      if (resp_st) begin
         cnt_d = cnt_q;
         if (tick_1us && (cnt_q != TMAX)) cnt_d = cnt_q + CW'(1);
      end
   end
   assign cnt_hit = resp_st && (cnt_d == TMAX);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_stb) state_d = SEND;
         SEND:    if (!uart_tx_busy) state_d = GAP;
         GAP: begin
            if (idx_q < frame_len) state_d = SEND;
            else if (!we_q)        state_d = RESP_HI;
            else                   state_d = DONE;
         end
         RESP_HI: begin
            if (rx_valid)     state_d = RESP_LO;
            else if (cnt_hit) state_d = DONE;
         end
         RESP_LO: if (rx_valid || cnt_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_busy    = (state_q != IDLE);
      o_done    = (state_q == DONE);
      o_timeout = (state_q == DONE) && to_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         hi_q       <= '0;
         dout_q     <= '0;
         tx_write_q <= 1'b0;
         tx_data_q  <= '0;
         to_q       <= 1'b0;
      end else begin
         tx_write_q <= tx_fire;
         cnt_q      <= cnt_d;
         to_q       <= resp_st && !rx_valid && cnt_hit;
         if ((state_q == IDLE) && i_stb) begin
            we_q   <= i_we;
            addr_q <= i_addr;
            din_q  <= i_din;
            idx_q  <= '0;
         end
         if (tx_fire) begin
            tx_data_q <= frame_byte;
            idx_q     <= idx_q + 3'd1;
         end
         // High byte is staged so a timeout after it leaves o_dout untouched.
         if ((state_q == RESP_HI) && rx_valid) hi_q <= rx_data;
         if ((state_q == RESP_LO) && rx_valid) dout_q <= {hi_q, rx_data};
      end
   end

   assign o_dout        = dout_q;
   assign uart_tx_write = tx_write_q;
   assign uart_tx_data  = tx_data_q;

endmodule
